fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage placed directly upstream of the single-cycle MIPS datapath. It owns the fetch PC, issues word requests to a wait-state instruction memory over a request/grant/response handshake, and buffers returned words with their PCs in a small queue. Instruction/PC pairs go to the core through a valid/ready handshake. A redirect from the branch logic flushes the queue and discards stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- DEPTH, 2, queue entries and max in-flight requests combined (power of two, ≥2)

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  32  new fetch target (word aligned)
- mem_req  output  1  fetch request valid
- mem_addr  output  32  fetch byte address
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  response word valid (in order)
- mem_rdata  input  32  response word
- instr_valid  output  1  instr/instr_pc valid to core
- instr  output  32  instruction word
- instr_pc  output  32  PC of instr
- instr_ready  input  1  core consumes instr this cycle

## Operation
- State: fetch_pc, resp_pc, queue (count 0..DEPTH), outstanding (0..DEPTH), drop_cnt, FSM {RUN, FLUSH}.
- RUN: mem_req = (count + outstanding < DEPTH); mem_addr = fetch_pc. On mem_req & mem_gnt: fetch_pc += 4, outstanding++.
- On mem_rvalid (RUN): push {mem_rdata, resp_pc}, resp_pc += 4, outstanding--. Credit rule guarantees no overflow; push to full queue is an assertion failure.
- Pop on instr_valid & instr_ready. Push and pop in the same cycle leave count unchanged.
- instr_valid = (count != 0); instr/instr_pc = head entry.
- Redirect (any state): queue cleared, fetch_pc = resp_pc = redirect_pc. drop_cnt = outstanding + (mem_gnt & mem_req) − mem_rvalid. The response in the redirect cycle is discarded. A grant in the redirect cycle counts as stale. If drop_cnt = 0 → RUN, else → FLUSH. A pop in the redirect cycle is ignored.
- FLUSH: mem_req = 0; each mem_rvalid discards the data and decrements drop_cnt; at 0 → RUN next cycle. A new redirect in FLUSH recomputes drop_cnt by the same formula.
- PC arithmetic modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.

## Timing
- Reset (asynchronous): FSM = RUN, count = outstanding = drop_cnt = 0, fetch_pc = resp_pc = RESET_PC. Outputs: mem_req 0, mem_addr RESET_PC, instr_valid 0, instr 0, instr_pc RESET_PC.
- First cycle after reset release: mem_req = 1, mem_addr = RESET_PC.
- mem_rvalid arrives no earlier than the cycle after its grant. mem_req/mem_addr are held stable until mem_gnt.
- Fetch latency without bypass: instr_valid rises the cycle after mem_rvalid.
- Redirect takes effect at the next edge. The first request to redirect_pc appears the cycle after the redirect (RUN), or the cycle after drop_cnt reaches 0 (FLUSH).
- Reset mid-operation drops all state. Any memory response after reset release that belongs to a pre-reset request is the memory's responsibility (memory is reset on the same reset).

## Configuration
- FETCH_BYPASS_EN defined: when count = 0, in RUN, no redirect and mem_rvalid = 1, the response drives instr/instr_pc and instr_valid combinationally in the same cycle. If instr_ready = 1 it is not enqueued; otherwise it is enqueued normally. Zero-cycle fetch latency.
- Undefined: all responses are registered through the queue. One cycle latency, and no combinational path from mem_* to instr_*.

## Structure
- Shared package fetch_pkg: FSM state encoding (RUN, FLUSH), PC_STEP = 4, INSTR_W = 32, RESET_PC default.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of {instr, pc} with push, pop, clear, count, head outputs, and the same clock/reset. fetch_unit holds the FSM, PC registers and credit counters.

## Test plan
- Reset release, memory grants immediately and responds 1 cycle later, instr_ready = 1: core sees PCs 0, 4, 8… with matching words. instr_valid first rises 2 cycles after release (1 with FETCH_BYPASS_EN).
- instr_ready = 0 for 10 cycles: at most DEPTH grants occur, mem_req then stays 0, queue holds PCs 0 and 4. On release, drain is in order with no loss.
- Redirect to 32'h0000_0100 with 2 requests outstanding: the next 2 mem_rvalid are discarded with mem_req = 0. Then mem_addr = 0x100, and the first delivered instr_pc = 0x100.
- Redirect in the same cycle as mem_rvalid and mem_gnt with outstanding = 1: drop_cnt = 1, and exactly one later response is discarded.
- RESET_PC = 32'hFFFF_FFF8: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-FLUSH: outputs return to reset values asynchronously, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of {instr, pc} pairs with synchronous clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             push_i,
  input  fetch_entry_t                     push_data_i,
  input  logic                             pop_i,
  input  logic                             clear_i,
  output logic [$clog2(DEPTH + 1)-1:0]     count_o,
  output fetch_entry_t                     head_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{instr: '0, pc: RESET_PC};
      end
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + {{(CW-1){1'b0}}, push_i} - {{(CW-1){1'b0}}, pop_i};
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // The upstream credit check must make a push into a full queue impossible.
  assert property (@(posedge clock) disable iff (!reset)
    !(push_i && !pop_i && !clear_i && count_q == DEPTH_C));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request/response credits, redirect flush.
// Optional same-cycle response bypass to the core: define FETCH_BYPASS_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [31:0]        mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  input  logic               instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          push, pop;
  logic          req_fire, live_resp, bypass_hit;

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .clear_i     (redirect_valid),
    .count_o     (count),
    .head_o      (head)
  );

  always_comb begin
    // Gated by reset so the request is low while reset is held yet rises in the first cycle after release.
    mem_req   = reset && (state_q == RUN) && (({1'b0, count} + {1'b0, out_q}) < DEPTH_C);
    mem_addr  = fetch_pc_q;
    req_fire  = mem_req && mem_gnt;
    live_resp = mem_rvalid && (state_q == RUN) && !redirect_valid;
`ifdef FETCH_BYPASS_EN
    bypass_hit = live_resp && (count == '0);
`else
    bypass_hit = 1'b0;
`endif
    instr_valid = (count != '0) || bypass_hit;
    instr       = bypass_hit ? mem_rdata : head.instr;
    instr_pc    = bypass_hit ? resp_pc_q : head.pc;

    push_data = '{instr: mem_rdata, pc: resp_pc_q};
    push      = live_resp && !(bypass_hit && instr_ready);
    pop       = (count != '0) && instr_ready && !redirect_valid;

    // Outstanding tracks every in-flight request, stale or not; drop_cnt mirrors it during FLUSH.
    out_d = out_q + {{(CW-1){1'b0}}, req_fire} - {{(CW-1){1'b0}}, mem_rvalid};

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + PC_STEP;
      if (live_resp) resp_pc_d  = resp_pc_q + PC_STEP;
    end

    state_d = state_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      drop_d  = out_d;
      state_d = (out_d == '0) ? RUN : FLUSH;
    end else if ((state_q == FLUSH) && mem_rvalid) begin
      drop_d = drop_q - 1'b1;
      if (drop_q == {{(CW-1){1'b0}}, 1'b1}) state_d = RUN;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

endmodule
